// File: rtl/input_read_ctrl_if.sv
// Handshake and memory-port bundle between the CPU/input ring and input_read_ctrl.
// The controller uses the slave modport; the CPU side plus mem_input use master.
interface input_read_ctrl_if #(
  parameter int unsigned LOG_MEM_INPUT_SIZE = 10
);
  logic [LOG_MEM_INPUT_SIZE:0]   QUEUE_T;
  logic [LOG_MEM_INPUT_SIZE-1:0] RD_ADDR;
  logic [31:0]                   RD_DATA;
  logic                          REQ;
  logic                          REQ_BYTE;
  logic                          FLUSH;
  logic                          ACK;
  logic [31:0]                   DOUT;
  logic                          STALL;
  logic [LOG_MEM_INPUT_SIZE:0]   QUEUE_H;
  logic                          OVERFLOW;

  modport master (
    output QUEUE_T, RD_DATA, REQ, REQ_BYTE, FLUSH,
    input  RD_ADDR, ACK, DOUT, STALL, QUEUE_H, OVERFLOW
  );

  modport slave (
    input  QUEUE_T, RD_DATA, REQ, REQ_BYTE, FLUSH,
    output RD_ADDR, ACK, DOUT, STALL, QUEUE_H, OVERFLOW
  );
endinterface

// File: rtl/input_read_ctrl.sv
// Consumer side of the UART input word ring: serves byte/word CPU reads from mem_input,
// tracks the read pointer against the loader's write count and flags ring overrun.
module input_read_ctrl #(
  parameter int unsigned MEM_INPUT_SIZE     = 1024,
  parameter int unsigned LOG_MEM_INPUT_SIZE = 10
) (
  input logic               CLK,
  input logic               RST,
  input_read_ctrl_if.slave  bus
);
  localparam int unsigned Log = LOG_MEM_INPUT_SIZE;

  localparam logic [Log:0]   PtrOne  = {{Log{1'b0}}, 1'b1};
  localparam logic [Log:0]   PtrTwo  = {{(Log-1){1'b0}}, 2'b10};
  localparam logic [Log:0]   MemSize = MEM_INPUT_SIZE[Log:0];
  localparam logic [Log-1:0] AddrOne = {{(Log-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRd1, StRd2, StResp} state_e;

  state_e         state_q;
  logic [1:0]     byte_ptr_q;
  logic [Log:0]   queue_h_q;
  logic [Log-1:0] rd_addr_q;
  logic [31:0]    dout_q;
  logic           ack_q;
  logic           overflow_q;
  logic           req_byte_q;
  logic           span_q;
  logic [31:0]    word_a_q;

  logic [Log:0]   avail;
  logic           ready;

  // Big-endian byte lane select: pointer 0 is the most significant byte.
  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] p);
    logic [7:0] b;
    case (p)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // Word straddling two ring entries: tail bytes of a followed by head bytes of b.
  function automatic logic [31:0] splice(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] p);
    logic [31:0] w;
    case (p)
      2'd1:    w = {a[23:0], b[31:24]};
      2'd2:    w = {a[15:0], b[31:16]};
      2'd3:    w = {a[7:0],  b[31:8]};
      default: w = a;
    endcase
    return w;
  endfunction

  always_comb begin
    avail = bus.QUEUE_T - queue_h_q;
    ready = (avail != '0) && (bus.REQ_BYTE || (byte_ptr_q == 2'd0) || (avail >= PtrTwo));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      byte_ptr_q <= 2'd0;
      queue_h_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      ack_q      <= 1'b0;
      overflow_q <= 1'b0;
      req_byte_q <= 1'b0;
      span_q     <= 1'b0;
      word_a_q   <= '0;
    end else if (bus.FLUSH) begin
      state_q    <= StIdle;
      queue_h_q  <= bus.QUEUE_T;
      byte_ptr_q <= 2'd0;
      overflow_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (avail > MemSize) begin
        overflow_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.REQ && ready) begin
            state_q    <= StRd1;
            req_byte_q <= bus.REQ_BYTE;
            span_q     <= !bus.REQ_BYTE && (byte_ptr_q != 2'd0);
            rd_addr_q  <= queue_h_q[Log-1:0];
          end
        end
        StRd1: begin
          word_a_q <= bus.RD_DATA;
          if (span_q) begin
            state_q   <= StRd2;
            rd_addr_q <= rd_addr_q + AddrOne;
          end else begin
            // Result is registered here so it appears together with ACK in RESP.
            state_q <= StResp;
            ack_q   <= 1'b1;
            if (req_byte_q) begin
              dout_q     <= {24'b0, sel_byte(bus.RD_DATA, byte_ptr_q)};
              byte_ptr_q <= byte_ptr_q + 2'd1;
              if (byte_ptr_q == 2'd3) begin
                queue_h_q <= queue_h_q + PtrOne;
              end
            end else begin
              dout_q    <= bus.RD_DATA;
              queue_h_q <= queue_h_q + PtrOne;
            end
          end
        end
        StRd2: begin
          state_q   <= StResp;
          ack_q     <= 1'b1;
          dout_q    <= splice(word_a_q, bus.RD_DATA, byte_ptr_q);
          queue_h_q <= queue_h_q + PtrOne;
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.RD_ADDR  = rd_addr_q;
  assign bus.ACK      = ack_q;
  assign bus.DOUT     = dout_q;
  assign bus.QUEUE_H  = queue_h_q;
  assign bus.OVERFLOW = overflow_q;
  assign bus.STALL    = bus.REQ & ~ack_q;
endmodule

// File: tb/tb_input_read_ctrl.sv
// Directed bench for input_read_ctrl: a vector table for the main read path plus
// hand-written sequences for stalls, ring wrap, overflow/flush and async reset.
module tb_input_read_ctrl;
  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  input_read_ctrl_if #(.LOG_MEM_INPUT_SIZE(10)) bus ();

  logic [31:0] mem [1024];
  assign bus.RD_DATA = mem[bus.RD_ADDR];

  input_read_ctrl #(
    .MEM_INPUT_SIZE     (1024),
    .LOG_MEM_INPUT_SIZE (10)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic        rb;
    logic [10:0] qt;
    logic [31:0] dout;
    int          lat;
    logic [10:0] qh;
  } vec_t;

  vec_t vecs [12];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    while (lat < 20) begin
      step();
      lat++;
      if (bus.ACK === 1'b1) break;
    end
    if (bus.ACK !== 1'b1) lat = -1;
  endtask

  task automatic do_req(input string name, input logic rb, input logic [10:0] qt,
                        input logic [31:0] exp_dout, input int exp_lat,
                        input logic [10:0] exp_qh);
    int lat;
    bus.QUEUE_T  = qt;
    bus.REQ_BYTE = rb;
    bus.REQ      = 1'b1;
    wait_ack(lat);
    bus.REQ = 1'b0;
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " DOUT"}, bus.DOUT, exp_dout);
    check({name, " QUEUE_H"}, {21'b0, bus.QUEUE_H}, {21'b0, exp_qh});
    step();
    check({name, " ACK pulse"}, {31'b0, bus.ACK}, 32'd0);
  endtask

  task automatic do_reset();
    RST          = 1'b1;
    bus.REQ      = 1'b0;
    bus.REQ_BYTE = 1'b0;
    bus.FLUSH    = 1'b0;
    bus.QUEUE_T  = '0;
    step();
    RST = 1'b0;
    step();
  endtask

  initial begin
    int  lat;
    bit  ok;

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    RST          = 1'b1;
    bus.REQ      = 1'b0;
    bus.REQ_BYTE = 1'b0;
    bus.FLUSH    = 1'b0;
    bus.QUEUE_T  = '0;
    step();
    check("reset ACK", {31'b0, bus.ACK}, 32'd0);
    check("reset DOUT", bus.DOUT, 32'd0);
    check("reset QUEUE_H", {21'b0, bus.QUEUE_H}, 32'd0);
    check("reset RD_ADDR", {22'b0, bus.RD_ADDR}, 32'd0);
    check("reset OVERFLOW", {31'b0, bus.OVERFLOW}, 32'd0);
    check("reset STALL", {31'b0, bus.STALL}, 32'd0);
    RST = 1'b0;
    step();

    // Main read path: word, four bytes, aligned word, spanning words at ptr 1 and 3.
    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'h11223344;
    mem[2] = 32'h55667788;
    mem[3] = 32'h99AABBCC;
    mem[4] = 32'hDDEEFF00;
    mem[5] = 32'h01020304;
    vecs[0]  = '{1'b0, 11'd1, 32'hDEADBEEF, 2, 11'd1};
    vecs[1]  = '{1'b1, 11'd2, 32'h00000011, 2, 11'd1};
    vecs[2]  = '{1'b1, 11'd2, 32'h00000022, 2, 11'd1};
    vecs[3]  = '{1'b1, 11'd2, 32'h00000033, 2, 11'd1};
    vecs[4]  = '{1'b1, 11'd2, 32'h00000044, 2, 11'd2};
    vecs[5]  = '{1'b0, 11'd3, 32'h55667788, 2, 11'd3};
    vecs[6]  = '{1'b1, 11'd5, 32'h00000099, 2, 11'd3};
    vecs[7]  = '{1'b0, 11'd5, 32'hAABBCCDD, 3, 11'd4};
    vecs[8]  = '{1'b1, 11'd5, 32'h000000EE, 2, 11'd4};
    vecs[9]  = '{1'b1, 11'd5, 32'h000000FF, 2, 11'd4};
    vecs[10] = '{1'b0, 11'd6, 32'h00010203, 3, 11'd5};
    vecs[11] = '{1'b1, 11'd6, 32'h00000004, 2, 11'd6};
    for (int i = 0; i < 12; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].rb, vecs[i].qt, vecs[i].dout, vecs[i].lat,
             vecs[i].qh);
    end

    // Empty queue: request stalls until data arrives.
    do_reset();
    mem[0]       = 32'hCAFEF00D;
    bus.REQ_BYTE = 1'b0;
    bus.REQ      = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      step();
      if (bus.STALL !== 1'b1 || bus.ACK !== 1'b0) ok = 1'b0;
    end
    check("empty stall", {31'b0, ok}, 32'd1);
    bus.QUEUE_T = 11'd1;
    wait_ack(lat);
    bus.REQ = 1'b0;
    check("empty release latency", 32'(lat), 32'd2);
    check("empty release DOUT", bus.DOUT, 32'hCAFEF00D);
    step();

    // Spanning word waits for the second ring entry.
    do_reset();
    mem[0] = 32'h11223344;
    mem[1] = 32'h55667788;
    do_req("span byte0", 1'b1, 11'd1, 32'h00000011, 2, 11'd0);
    bus.REQ_BYTE = 1'b0;
    bus.REQ      = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      step();
      if (bus.STALL !== 1'b1 || bus.ACK !== 1'b0) ok = 1'b0;
    end
    check("span stall", {31'b0, ok}, 32'd1);
    bus.QUEUE_T = 11'd2;
    wait_ack(lat);
    bus.REQ = 1'b0;
    check("span latency", 32'(lat), 32'd3);
    check("span DOUT", bus.DOUT, 32'h22334455);
    check("span QUEUE_H", {21'b0, bus.QUEUE_H}, 32'd1);
    step();
    do_req("span ptr kept", 1'b1, 11'd2, 32'h00000066, 2, 11'd1);

    // Ring wrap: spanning read from index 1023 into index 0.
    do_reset();
    bus.QUEUE_T = 11'd1023;
    bus.FLUSH   = 1'b1;
    step();
    bus.FLUSH = 1'b0;
    check("wrap flush QUEUE_H", {21'b0, bus.QUEUE_H}, 32'd1023);
    mem[1023] = 32'hA1B2C3D4;
    mem[0]    = 32'hE5F60718;
    do_req("wrap byte0", 1'b1, 11'd1025, 32'h000000A1, 2, 11'd1023);
    do_req("wrap byte1", 1'b1, 11'd1025, 32'h000000B2, 2, 11'd1023);
    bus.REQ_BYTE = 1'b0;
    bus.REQ      = 1'b1;
    step();
    check("wrap RD_ADDR first", {22'b0, bus.RD_ADDR}, 32'd1023);
    step();
    check("wrap RD_ADDR second", {22'b0, bus.RD_ADDR}, 32'd0);
    check("wrap no early ACK", {31'b0, bus.ACK}, 32'd0);
    step();
    bus.REQ = 1'b0;
    check("wrap ACK", {31'b0, bus.ACK}, 32'd1);
    check("wrap DOUT", bus.DOUT, 32'hC3D4E5F6);
    check("wrap QUEUE_H", {21'b0, bus.QUEUE_H}, 32'd1024);
    step();

    // Overflow is sticky; FLUSH in RD1 drops the request and clears it.
    do_reset();
    bus.QUEUE_T = 11'd1025;
    step();
    check("overflow set", {31'b0, bus.OVERFLOW}, 32'd1);
    bus.QUEUE_T = 11'd0;
    step();
    check("overflow sticky", {31'b0, bus.OVERFLOW}, 32'd1);
    bus.QUEUE_T  = 11'd1025;
    bus.REQ_BYTE = 1'b0;
    bus.REQ      = 1'b1;
    step();
    bus.REQ   = 1'b0;
    bus.FLUSH = 1'b1;
    step();
    bus.FLUSH = 1'b0;
    check("flush OVERFLOW", {31'b0, bus.OVERFLOW}, 32'd0);
    check("flush QUEUE_H", {21'b0, bus.QUEUE_H}, 32'd1025);
    ok = 1'b1;
    repeat (5) begin
      if (bus.ACK !== 1'b0) ok = 1'b0;
      step();
    end
    check("flush no ACK", {31'b0, ok}, 32'd1);

    // Accepted request completes even though REQ drops right after accept.
    mem[1]       = 32'h0BADF00D;
    bus.QUEUE_T  = 11'd1026;
    bus.REQ_BYTE = 1'b0;
    bus.REQ      = 1'b1;
    step();
    bus.REQ = 1'b0;
    wait_ack(lat);
    check("early drop latency", 32'(lat), 32'd1);
    check("early drop DOUT", bus.DOUT, 32'h0BADF00D);
    check("early drop QUEUE_H", {21'b0, bus.QUEUE_H}, 32'd1026);
    step();

    // Asynchronous reset in the middle of a read.
    bus.QUEUE_T = 11'd1027;
    bus.REQ     = 1'b1;
    step();
    RST = 1'b1;
    #1;
    check("async rst QUEUE_H", {21'b0, bus.QUEUE_H}, 32'd0);
    check("async rst RD_ADDR", {22'b0, bus.RD_ADDR}, 32'd0);
    check("async rst DOUT", bus.DOUT, 32'd0);
    bus.REQ = 1'b0;
    step();
    check("async rst ACK", {31'b0, bus.ACK}, 32'd0);
    RST = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
